// File: rtl/alu_stage_reg.sv
// EX/MEM pipeline stage register with valid/ready handshake, optional skid entry,
// flush, bubble gating of side-effecting controls, and a saturating stall counter.
module alu_stage_reg #(
  parameter int XLEN  = 32,
  parameter int RD_W  = 5,
  parameter int SKID  = 1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             mem_write_en_i,
  input  logic             mem_read_i,
  input  logic             mem_to_reg_i,
  input  logic [RD_W-1:0]  rd_i,
  input  logic [XLEN-1:0]  alu_val_i,
  input  logic [XLEN-1:0]  mem_addr_i,
  input  logic [2:0]       funct3_i,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             mem_write_en,
  output logic             mem_read,
  output logic             mem_to_reg,
  output logic [RD_W-1:0]  rd,
  output logic [XLEN-1:0]  alu_val,
  output logic [XLEN-1:0]  mem_addr,
  output logic [2:0]       funct3,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef struct packed {
    logic            mem_we;
    logic            mem_rd;
    logic            mem_to_reg;
    logic [RD_W-1:0] rd;
    logic [XLEN-1:0] alu_val;
    logic [XLEN-1:0] mem_addr;
    logic [2:0]      funct3;
  } beat_t;

  beat_t            in_beat, main_q, main_d, skid_q, skid_d;
  logic             valid_q, valid_d, skid_valid_q, skid_valid_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic             accept, consume;

  assign in_beat = '{mem_we: mem_write_en_i, mem_rd: mem_read_i, mem_to_reg: mem_to_reg_i,
                     rd: rd_i, alu_val: alu_val_i, mem_addr: mem_addr_i, funct3: funct3_i};

  // With a skid entry, readiness is purely registered state; rst_n only masks it.
  generate
    if (SKID != 0) begin : g_skid
      assign in_ready = rst_n & ~skid_valid_q;
    end else begin : g_noskid
      assign in_ready = rst_n & (out_ready | ~valid_q);
    end
  endgenerate

  assign accept  = in_valid & in_ready & ~flush;
  assign consume = valid_q & out_ready;

  always_comb begin
    main_d       = main_q;
    skid_d       = skid_q;
    valid_d      = valid_q;
    skid_valid_d = skid_valid_q;
    stall_d      = stall_q;
    if (valid_q && !out_ready && !flush && stall_q != '1)
      stall_d = stall_q + CNT_W'(1);
    if (flush) begin
      valid_d      = 1'b0;
      skid_valid_d = 1'b0;
    end else if (consume || !valid_q) begin
      // Main slot frees up: the older skid beat has priority over a new one.
      if (SKID != 0 && skid_valid_q) begin
        main_d       = skid_q;
        valid_d      = 1'b1;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        main_d  = in_beat;
        valid_d = 1'b1;
      end else begin
        valid_d = 1'b0;
      end
    end else if (SKID != 0 && accept) begin
      skid_d       = in_beat;
      skid_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      main_q       <= '0;
      skid_q       <= '0;
      valid_q      <= 1'b0;
      skid_valid_q <= 1'b0;
      stall_q      <= '0;
    end else begin
      main_q       <= main_d;
      skid_q       <= skid_d;
      valid_q      <= valid_d;
      skid_valid_q <= skid_valid_d;
      stall_q      <= stall_d;
    end
  end

  // Bubbles must never write memory or target a register.
  assign out_valid    = valid_q;
  assign mem_write_en = valid_q & main_q.mem_we;
  assign mem_read     = valid_q & main_q.mem_rd;
  assign mem_to_reg   = valid_q & main_q.mem_to_reg;
  assign rd           = valid_q ? main_q.rd : '0;
  assign alu_val      = main_q.alu_val;
  assign mem_addr     = main_q.mem_addr;
  assign funct3       = main_q.funct3;
  assign stall_cnt    = stall_q;

endmodule
